menger_sdf_iter: RTL and testbench

- Parametrised multi-cycle Menger sponge signed-distance estimator for the ray marcher; the successor to the fixed-depth Menger SDF.
- Given a fixed-point ray point (x,y,z), it returns a conservative distance to a sponge of configurable size and recursion depth.
- It also returns the recursion level that set the distance and a per-level shaded RGB colour.
- Sits between the march-step controller and the shader, using the same level start/done handshake.

---
 rtl/menger_sdf_iter.sv | 161 ++++++++++++++++
 tb/tb_menger_sdf_iter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/menger_sdf_iter.sv
// menger_sdf_iter: multi-cycle Menger sponge distance estimator with level and shaded colour
module menger_sdf_iter #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 3,
  parameter int LOG2_HALF  = 5,
  parameter int BASE_R     = 255,
  parameter int BASE_G     = 255,
  parameter int BASE_B     = 255,
  parameter int SHADE_STEP = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sdf_start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             sdf_busy,
  output logic             sdf_done,
  output logic [WIDTH-1:0] sdf_out,
  output logic [2:0]       sdf_level,
  output logic [7:0]       sdf_red_out,
  output logic [7:0]       sdf_green_out,
  output logic [7:0]       sdf_blue_out
);
  localparam int IW = WIDTH + 4;
  typedef logic signed [IW-1:0] sw_t;
  typedef enum logic [2:0] {IDLE, LOAD, ITER_A, ITER_B, FINISH, DONE} state_t;

  // round(2^FRAC / 3^k) as floor((2^(FRAC+1) + 3^k) / (2*3^k))
  function automatic sw_t inv3(input int k);
    longint p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 3;
    return sw_t'(((longint'(2) << FRAC) + p) / (2 * p));
  endfunction

  localparam sw_t ONE = sw_t'(1) <<< FRAC;
  localparam sw_t INV3 [6] = '{inv3(1), inv3(2), inv3(3), inv3(4), inv3(5), inv3(6)};

  function automatic sw_t sabs(input sw_t v);
    return v < 0 ? -v : v;
  endfunction

  function automatic sw_t smax(input sw_t a, input sw_t b);
    return a > b ? a : b;
  endfunction

  function automatic sw_t smin(input sw_t a, input sw_t b);
    return a < b ? a : b;
  endfunction

  // fold distance of a reduced coordinate to the centre-third slab: |1 - 3|u - 1||
  function automatic sw_t rfold(input logic [FRAC:0] u);
    sw_t a;
    a = sabs(sw_t'({1'b0, u}) - ONE);
    return sabs(ONE - ((a <<< 1) + a));
  endfunction

  function automatic logic [7:0] shade(input int base, input logic [2:0] l);
    int v;
    v = base - int'(l) * SHADE_STEP;
    return v < 0 ? 8'd0 : 8'(v);
  endfunction

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] px, py, pz;
  logic [FRAC:0] ux, uy, uz;
  sw_t d, t, qx, qy, qz, rx, ry, rz, c;
  logic signed [2*IW-1:0] prod;
  logic [2:0] lvl, m;
  logic last;

  always_comb begin
    qx = sw_t'(px) >>> LOG2_HALF;
    qy = sw_t'(py) >>> LOG2_HALF;
    qz = sw_t'(pz) >>> LOG2_HALF;
    rx = rfold(ux);
    ry = rfold(uy);
    rz = rfold(uz);
    prod = t * INV3[m];
    c = sw_t'(prod >>> FRAC);
    last = int'(m) + 1 >= ITERATIONS;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (sdf_start && !sdf_done) ? LOAD : IDLE;
      LOAD:    state_d = ITER_A;
      ITER_A:  state_d = ITER_B;
      ITER_B:  state_d = last ? FINISH : ITER_A;
      FINISH:  state_d = DONE;
      DONE:    state_d = sdf_start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      px <= '0;
      py <= '0;
      pz <= '0;
      ux <= '0;
      uy <= '0;
      uz <= '0;
      d <= '0;
      t <= '0;
      lvl <= '0;
      m <= '0;
      sdf_busy <= 1'b0;
      sdf_done <= 1'b0;
      sdf_out <= '0;
      sdf_level <= '0;
      sdf_red_out <= '0;
      sdf_green_out <= '0;
      sdf_blue_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (sdf_start && !sdf_done) begin
          px <= x;
          py <= y;
          pz <= z;
          sdf_busy <= 1'b1;
        end
        LOAD: begin
          d <= smax(smax(sabs(qx), sabs(qy)), sabs(qz)) - ONE;
          lvl <= '0;
          ux <= qx[FRAC:0];
          uy <= qy[FRAC:0];
          uz <= qz[FRAC:0];
          m <= '0;
        end
        ITER_A: t <= smin(smin(smax(rx, ry), smax(ry, rz)), smax(rz, rx)) - ONE;
        ITER_B: begin
          if (c > d) begin
            d <= c;
            lvl <= m + 3'd1;
          end
          ux <= ux + {ux[FRAC-1:0], 1'b0};
          uy <= uy + {uy[FRAC-1:0], 1'b0};
          uz <= uz + {uz[FRAC-1:0], 1'b0};
          m <= m + 3'd1;
        end
        FINISH: begin
          sdf_out <= WIDTH'(d <<< LOG2_HALF);
          sdf_level <= lvl;
          sdf_red_out <= shade(BASE_R, lvl);
          sdf_green_out <= shade(BASE_G, lvl);
          sdf_blue_out <= shade(BASE_B, lvl);
          sdf_busy <= 1'b0;
          sdf_done <= 1'b1;
        end
        DONE: if (!sdf_start) sdf_done <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_menger_sdf_iter.sv
// tb_menger_sdf_iter: directed scoreboard bench over three parameterisations of the sponge estimator
`timescale 1ns/1ps
module tb_menger_sdf_iter;
  typedef struct {
    int          dut;
    logic [31:0] o;
    logic [2:0]  lv;
    logic [7:0]  col;
  } exp_t;

  logic clk = 0, rst = 1;
  logic start [3];
  logic [31:0] xi, yi, zi;
  logic busy [3], done [3];
  logic [31:0] o [3];
  logic [2:0] lv [3];
  logic [7:0] r [3], g [3], b [3];
  logic pdone [3];
  exp_t sb [$];
  int errors = 0, checks = 0;
  int nits [3] = '{1, 1, 3};

  always #5 clk = ~clk;

  menger_sdf_iter #(.WIDTH(32), .FRAC(16), .ITERATIONS(1), .LOG2_HALF(0)) d0 (
    .clk_in(clk), .rst_in(rst), .sdf_start(start[0]), .x(xi), .y(yi), .z(zi),
    .sdf_busy(busy[0]), .sdf_done(done[0]), .sdf_out(o[0]), .sdf_level(lv[0]),
    .sdf_red_out(r[0]), .sdf_green_out(g[0]), .sdf_blue_out(b[0]));

  menger_sdf_iter #(.WIDTH(32), .FRAC(16), .ITERATIONS(1), .LOG2_HALF(5)) d5 (
    .clk_in(clk), .rst_in(rst), .sdf_start(start[1]), .x(xi), .y(yi), .z(zi),
    .sdf_busy(busy[1]), .sdf_done(done[1]), .sdf_out(o[1]), .sdf_level(lv[1]),
    .sdf_red_out(r[1]), .sdf_green_out(g[1]), .sdf_blue_out(b[1]));

  menger_sdf_iter #(.WIDTH(32), .FRAC(16), .ITERATIONS(3), .LOG2_HALF(0)) d3 (
    .clk_in(clk), .rst_in(rst), .sdf_start(start[2]), .x(xi), .y(yi), .z(zi),
    .sdf_busy(busy[2]), .sdf_done(done[2]), .sdf_out(o[2]), .sdf_level(lv[2]),
    .sdf_red_out(r[2]), .sdf_green_out(g[2]), .sdf_blue_out(b[2]));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", n, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // monitor: every rising sdf_done on any instance retires the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1 && pdone[i] !== 1'b1) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("dut_tag%0d", i), i, e.dut);
          chk($sformatf("sdf_out%0d", i), o[i], e.o);
          chk($sformatf("level%0d", i), 32'(lv[i]), 32'(e.lv));
          chk($sformatf("red%0d", i), 32'(r[i]), 32'(e.col));
          chk($sformatf("green%0d", i), 32'(g[i]), 32'(e.col));
          chk($sformatf("blue%0d", i), 32'(b[i]), 32'(e.col));
        end
      end
      pdone[i] = done[i];
    end
  end

  task automatic req(input int i, input logic [31:0] xv, yv, zv, eo, input int el, input int ec, input int hold);
    exp_t e;
    int k;
    e.dut = i; e.o = eo; e.lv = 3'(el); e.col = 8'(ec);
    sb.push_back(e);
    @(negedge clk);
    xi = xv; yi = yv; zi = zv;
    start[i] = 1;
    @(posedge clk);
    #1;
    chk("busy_on_accept", 32'(busy[i]), 32'd1);
    xi = 32'h7fff_0000; yi = 32'h8000_1234; zi = 32'h0001_ffff;
    k = 0;
    while (done[i] !== 1'b1 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", k, 2 * nits[i] + 2);
    repeat (hold) @(posedge clk);
    #1;
    chk("done_held", 32'(done[i]), 32'd1);
    chk("busy_after_done", 32'(busy[i]), 32'd0);
    @(negedge clk);
    start[i] = 0;
    @(posedge clk);
    #1;
    chk("done_cleared", 32'(done[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 0;
      pdone[i] = 0;
    end
    xi = 0; yi = 0; zi = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_out", o[i], 32'd0);
      chk("rst_red", 32'(r[i]), 32'd0);
    end
    @(negedge clk);
    rst = 0;
    req(0, 32'd0, 32'd0, 32'd0, 32'd21845, 1, 191, 10);
    chk("one_computation", sb.size(), 0);
    req(0, 32'd131072, 32'd0, 32'd0, 32'd65536, 0, 255, 0);
    req(0, 32'd32768, 32'd32768, 32'd32768, -32'sd10923, 1, 191, 2);
    req(0, -32'sd65536, 32'd0, 32'd0, 32'd21845, 1, 191, 0);
    req(1, 32'd0, 32'd0, 32'd0, 32'd699040, 1, 191, 1);
    req(2, 32'd0, 32'd0, 32'd0, 32'd21845, 1, 191, 0);
    req(2, 32'd65536, 32'd65536, 32'd0, 32'd0, 0, 255, 0);
    // abort an N=3 run during its first ITER_A
    @(negedge clk);
    xi = 32'd43691; yi = 32'd43691; zi = 32'd43691;
    start[2] = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy[2]), 32'd1);
    rst = 1;
    #1;
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_done", 32'(done[2]), 32'd0);
    chk("abort_out", o[2], 32'd0);
    chk("abort_level", 32'(lv[2]), 32'd0);
    chk("abort_red", 32'(r[2]), 32'd0);
    start[2] = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done[2]), 32'd0);
    req(2, 32'd43691, 32'd43691, 32'd43691, 32'd7281, 2, 127, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
